// File: rtl/aes_pkg.sv
// Shared AES front-end types.
//   BLOCK_BITS / FRAME_BITS : block width and SPI frame length
//   block_t                 : one 128-bit AES block
//   state_t                 : front-end sequencing states
package aes_pkg;
    localparam int BLOCK_BITS = 128;
    localparam int FRAME_BITS = 256;

    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection on the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronized level (last synchronizer stage)
//   rise, fall : one-clk pulses on synchronized level transitions
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front end for aes_core, fully in the clk domain.
//   clk, reset        : system clock, synchronous active-high reset
//   sck, sdi, load    : asynchronous SPI inputs from the MCU
//   sdo, done         : registered cyphertext bit stream and result-held flag
//   key, plaintext    : latched frame halves driven to the core
//   core_start        : one-clk start pulse to the core
//   core_done         : core completion (level or pulse)
//   cyphertext        : core result, valid with core_done
module aes_spi_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int BLOCK_BITS  = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    output logic                  sdo,
    output logic                  done,
    output logic [BLOCK_BITS-1:0] key,
    output logic [BLOCK_BITS-1:0] plaintext,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [BLOCK_BITS-1:0] cyphertext
);
    import aes_pkg::*;

    localparam int FRAME_W = 2 * BLOCK_BITS;
    localparam int ICW     = $clog2(FRAME_W + 1);
    localparam int OCW     = $clog2(BLOCK_BITS + 1);
    localparam logic [ICW-1:0] IN_FULL  = ICW'(FRAME_W);
    localparam logic [OCW-1:0] OUT_FULL = OCW'(BLOCK_BITS);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(BLOCK_BITS - 1);

    logic sck_lvl_unused, sck_rise, sck_fall_unused;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;
    logic load_lvl, load_rise, load_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall_unused)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset(reset), .din(sdi),
        .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset(reset), .din(load),
        .level(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    state_t               state, state_next;
    logic [FRAME_W-1:0]    frame;
    logic [ICW-1:0]        in_cnt, in_base;
    logic [BLOCK_BITS-1:0] out_reg;
    logic [OCW-1:0]        out_cnt;
    logic shift_in, latch, discard, capture, shift_out, abort;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // A load rise outranks everything; an sck rise on the same clk still
    // counts as the first bit because load_lvl is already high then.
    always_comb begin
        state_next = state;
        shift_in   = 1'b0;
        latch      = 1'b0;
        discard    = 1'b0;
        capture    = 1'b0;
        shift_out  = 1'b0;
        abort      = 1'b0;
        if (load_rise) begin
            abort      = 1'b1;
            shift_in   = sck_rise;
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fall) begin
                        if (in_cnt == IN_FULL) begin
                            latch      = 1'b1;
                            state_next = WAIT;
                        end else begin
                            discard = 1'b1;
                        end
                    end else if (sck_rise && load_lvl) begin
                        shift_in = 1'b1;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        capture    = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT:   shift_out  = sck_rise;
                default: state_next = LOAD;
            endcase
        end
    end

    assign in_base = abort ? '0 : in_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame      <= '0;
            in_cnt     <= '0;
            out_reg    <= '0;
            out_cnt    <= '0;
            sdo        <= 1'b0;
            done       <= 1'b0;
            key        <= '0;
            plaintext  <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= latch;
            // Shift register keeps only the most recent FRAME_W bits.
            if (shift_in) begin
                frame  <= {frame[FRAME_W-2:0], sdi_lvl};
                in_cnt <= (in_base == IN_FULL) ? IN_FULL : in_base + 1'b1;
            end else if (abort || discard) begin
                in_cnt <= '0;
            end
            if (latch) begin
                plaintext <= frame[FRAME_W-1:BLOCK_BITS];
                key       <= frame[BLOCK_BITS-1:0];
            end
            if (abort) begin
                done <= 1'b0;
                sdo  <= 1'b0;
            end
            if (capture) begin
                out_reg <= cyphertext;
                sdo     <= cyphertext[BLOCK_BITS-1];
                done    <= 1'b1;
                out_cnt <= '0;
            end
            // sdo moves only after a synchronized rise, i.e. well after the
            // MCU has sampled the previous bit.
            if (shift_out) begin
                out_reg <= {out_reg[BLOCK_BITS-2:0], 1'b0};
                if (out_cnt != OUT_FULL) out_cnt <= out_cnt + 1'b1;
                sdo <= (out_cnt < OUT_LAST) ? out_reg[BLOCK_BITS-2] : 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_spi_frontend.sv
module tb_aes_spi_frontend;
    localparam int S = 2;
    localparam int B = 128;
    localparam int F = 256;

    localparam logic [B-1:0] A1_PT = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [B-1:0] A1_KY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [B-1:0] A1_CT = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [B-1:0] C1_PT = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [B-1:0] C1_KY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [B-1:0] C1_CT = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    logic clk = 1'b0, reset = 1'b1, sck = 1'b0, sdi = 1'b0, load = 1'b0;
    logic core_done = 1'b0;
    logic [B-1:0] cyphertext = '0;
    logic sdo, done, core_start;
    logic [B-1:0] key, plaintext;

    int errors = 0, checks = 0, start_cnt = 0;
    int mock_delay = 12, mock_timer = 0, jit_max = 9;
    bit mock_level = 1'b0;
    bit tx_q[$];
    logic [B-1:0] m_pt = '0, m_key = '0;

    always #5 clk = ~clk;

    aes_spi_frontend #(.SYNC_STAGES(S), .BLOCK_BITS(B)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .done(done), .key(key), .plaintext(plaintext),
        .core_start(core_start), .core_done(core_done), .cyphertext(cyphertext)
    );

    // Mock core: known vectors for the FIPS examples, a simple mix otherwise.
    function automatic logic [B-1:0] ref_ct(input logic [B-1:0] p, input logic [B-1:0] k);
        if (p == A1_PT && k == A1_KY) return A1_CT;
        if (p == C1_PT && k == C1_KY) return C1_CT;
        return p ^ {k[63:0], k[127:64]};
    endfunction

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            if (mock_delay == 0) begin
                core_done  = 1'b1;
                cyphertext = ref_ct(plaintext, key);
            end else begin
                core_done  = 1'b0;
                mock_timer = mock_delay;
            end
        end else if (mock_timer > 0) begin
            mock_timer--;
            if (mock_timer == 0) begin
                core_done  = 1'b1;
                cyphertext = ref_ct(plaintext, key);
            end
        end else if (!mock_level) begin
            core_done = 1'b0;
        end
    end

    // Delays never land exactly on a rising clk edge.
    task automatic wait_ns(input int ns);
        #(ns);
        if (($time % 10) == 5) #1;
    endtask

    task automatic spi_clock(input logic b, output logic s);
        sdi = b;
        wait_ns(40 + int'($urandom_range(0, jit_max)));
        s   = sdo;
        sck = 1'b1;
        wait_ns(40 + int'($urandom_range(0, jit_max)));
        sck = 1'b0;
    endtask

    task automatic send_frame();
        logic s;
        load = 1'b1;
        wait_ns(60);
        foreach (tx_q[i]) spi_clock(tx_q[i], s);
        wait_ns(40);
        load = 1'b0;
        wait_ns(30);
    endtask

    task automatic read_bits(input int n, output logic [B-1:0] w);
        logic s;
        w = '0;
        for (int i = 0; i < n; i++) begin
            spi_clock(1'b0, s);
            w = {w[B-2:0], s};
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic load_vec(input logic [F-1:0] v);
        tx_q.delete();
        for (int i = F - 1; i >= 0; i--) tx_q.push_back(v[i]);
    endtask

    task automatic load_rand(input int n);
        tx_q.delete();
        repeat (n) tx_q.push_back(1'($urandom));
    endtask

    // The last 256 bits sent, first of them at the MSB.
    function automatic logic [F-1:0] last_frame();
        logic [F-1:0] v;
        for (int i = 0; i < F; i++) v[i] = tx_q[tx_q.size() - 1 - i];
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (sdo !== 1'b0)       begin errors++; $display("FAIL reset_sdo: got %b want 0", sdo); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (core_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", core_start); end
        if (key !== '0)         begin errors++; $display("FAIL reset_key: got %h want 0", key); end
        if (plaintext !== '0)   begin errors++; $display("FAIL reset_pt: got %h want 0", plaintext); end
    endtask

    task automatic test_fips();
        bit ok; int base; logic [B-1:0] w;
        base = start_cnt;
        load_vec({A1_PT, A1_KY});
        m_pt = A1_PT; m_key = A1_KY;
        send_frame();
        wait_done(ok);
        checks += 7;
        if (!ok) begin errors++; $display("FAIL fips_done: got timeout want done=1"); end
        if (plaintext !== A1_PT) begin errors++; $display("FAIL fips_pt: got %h want %h", plaintext, A1_PT); end
        if (key !== A1_KY) begin errors++; $display("FAIL fips_key: got %h want %h", key, A1_KY); end
        read_bits(B, w);
        if (w !== A1_CT) begin errors++; $display("FAIL fips_sdo: got %h want %h", w, A1_CT); end
        read_bits(4, w);
        if (w[3:0] !== 4'h0) begin errors++; $display("FAIL fips_tail: got %h want 0", w[3:0]); end
        if (done !== 1'b1) begin errors++; $display("FAIL fips_done_held: got %b want 1", done); end
        if (start_cnt - base != 1) begin errors++; $display("FAIL fips_starts: got %0d want 1", start_cnt - base); end
    endtask

    task automatic test_short();
        int base;
        base = start_cnt;
        load_rand(200);
        send_frame();
        repeat (40) @(negedge clk);
        checks += 4;
        if (start_cnt != base) begin errors++; $display("FAIL short_starts: got %0d want 0", start_cnt - base); end
        if (done !== 1'b0) begin errors++; $display("FAIL short_done: got %b want 0", done); end
        if (key !== m_key) begin errors++; $display("FAIL short_key: got %h want %h", key, m_key); end
        if (plaintext !== m_pt) begin errors++; $display("FAIL short_pt: got %h want %h", plaintext, m_pt); end
    endtask

    task automatic test_long();
        bit ok; int base; logic [B-1:0] w; logic [F-1:0] exp_f;
        base = start_cnt;
        load_rand(260);
        exp_f = last_frame();
        m_pt = exp_f[F-1:B]; m_key = exp_f[B-1:0];
        send_frame();
        wait_done(ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL long_done: got timeout want done=1"); end
        if (plaintext !== m_pt) begin errors++; $display("FAIL long_pt: got %h want %h", plaintext, m_pt); end
        if (key !== m_key) begin errors++; $display("FAIL long_key: got %h want %h", key, m_key); end
        if (start_cnt - base != 1) begin errors++; $display("FAIL long_starts: got %0d want 1", start_cnt - base); end
        read_bits(B, w);
        if (w !== ref_ct(m_pt, m_key)) begin errors++; $display("FAIL long_sdo: got %h want %h", w, ref_ct(m_pt, m_key)); end
    endtask

    task automatic test_abort();
        bit ok; logic [B-1:0] w, exp_ct; logic [F-1:0] exp_f;
        load_rand(256);
        exp_f = last_frame();
        exp_ct = ref_ct(exp_f[F-1:B], exp_f[B-1:0]);
        send_frame();
        wait_done(ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL abort_first_done: got timeout want done=1"); end
        read_bits(40, w);
        if (w[39:0] !== exp_ct[B-1:B-40]) begin errors++; $display("FAIL abort_40bits: got %h want %h", w[39:0], exp_ct[B-1:B-40]); end
        load = 1'b1;
        wait_ns((S + 2) * 10);
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        if (sdo !== 1'b0) begin errors++; $display("FAIL abort_sdo: got %b want 0", sdo); end
        load_vec({C1_PT, C1_KY});
        m_pt = C1_PT; m_key = C1_KY;
        send_frame();
        wait_done(ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL c1_done: got timeout want done=1"); end
        if (plaintext !== C1_PT) begin errors++; $display("FAIL c1_pt: got %h want %h", plaintext, C1_PT); end
        if (key !== C1_KY) begin errors++; $display("FAIL c1_key: got %h want %h", key, C1_KY); end
        read_bits(B, w);
        if (w !== C1_CT) begin errors++; $display("FAIL c1_sdo: got %h want %h", w, C1_CT); end
    endtask

    task automatic test_reset_wait();
        bit ok; int base;
        base = start_cnt;
        load_rand(256);
        send_frame();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (start_cnt != base) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pt = '0; m_key = '0;
        checks += 5;
        if (!ok) begin errors++; $display("FAIL rstw_start: got timeout want core_start"); end
        if (done !== 1'b0 || sdo !== 1'b0) begin errors++; $display("FAIL rstw_flags: got done=%b sdo=%b want 0 0", done, sdo); end
        if (key !== '0 || plaintext !== '0) begin errors++; $display("FAIL rstw_data: got key=%h pt=%h want 0", key, plaintext); end
        repeat (30) @(negedge clk);
        if (done !== 1'b0) begin errors++; $display("FAIL rstw_late_done: got %b want 0", done); end
        if (sdo !== 1'b0) begin errors++; $display("FAIL rstw_late_sdo: got %b want 0", sdo); end
    endtask

    task automatic test_min_timing();
        bit ok; logic [B-1:0] w; logic [F-1:0] exp_f;
        jit_max = 3;
        for (int it = 0; it < 3; it++) begin
            mock_delay = int'($urandom_range(1, 20));
            load_rand(256);
            exp_f = last_frame();
            m_pt = exp_f[F-1:B]; m_key = exp_f[B-1:0];
            send_frame();
            wait_done(ok);
            checks += 3;
            if (!ok) begin errors++; $display("FAIL min_done[%0d]: got timeout want done=1", it); end
            if ({plaintext, key} !== exp_f) begin errors++; $display("FAIL min_frame[%0d]: got %h want %h", it, {plaintext, key}, exp_f); end
            read_bits(B, w);
            if (w !== ref_ct(m_pt, m_key)) begin errors++; $display("FAIL min_sdo[%0d]: got %h want %h", it, w, ref_ct(m_pt, m_key)); end
        end
        jit_max = 9;
        mock_delay = 12;
    endtask

    task automatic test_level_done();
        bit ok; logic [B-1:0] w; logic [F-1:0] exp_f;
        mock_delay = 0;
        mock_level = 1'b1;
        load_rand(256);
        exp_f = last_frame();
        m_pt = exp_f[F-1:B]; m_key = exp_f[B-1:0];
        send_frame();
        wait_done(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL level_done: got timeout want done=1"); end
        read_bits(B, w);
        if (w !== ref_ct(m_pt, m_key)) begin errors++; $display("FAIL level_sdo: got %h want %h", w, ref_ct(m_pt, m_key)); end
        mock_level = 1'b0;
        mock_delay = 12;
    endtask

    initial begin
        test_reset();
        test_fips();
        test_short();
        test_long();
        test_abort();
        test_reset_wait();
        test_min_timing();
        test_level_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
